frame_block_writer: RTL and testbench

- Write-side counterpart of the frame-memory block reader.
- Accepts a raster-order 8-bit pixel stream (320x240) and packs each run of 4 horizontal pixels into one 32-bit word.
- Writes each word into the 4x4-block-organised frame memory: one block address plus a word select (block row).
- Sits between the pixel source (camera/renderer) and the frameMem write port.

---
 rtl/fb_pkg.sv | 20 ++
 rtl/pixel_packer.sv | 40 ++++
 rtl/frame_block_writer.sv | 121 ++++++++++++
 tb/tb_frame_block_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-memory geometry and write-request payload for the block reader/writer pair.
package fb_pkg;

    localparam int unsigned H_PIX        = 320;
    localparam int unsigned V_PIX        = 240;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned BLK_DIM      = 4;
    localparam int unsigned BLKS_PER_ROW = H_PIX / BLK_DIM;
    localparam int unsigned NUM_BLKS     = BLKS_PER_ROW * (V_PIX / BLK_DIM);
    localparam int unsigned ADDR_W       = 13;
    localparam int unsigned SEL_W        = 2;
    localparam int unsigned WORD_W       = BLK_DIM * PIX_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [WORD_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/pixel_packer.sv
// Four-lane pixel packer: collects pixels left to right and strobes when the 4th arrives.
module pixel_packer #(
    parameter int unsigned PIX_W = 8
) (
    input  logic               GCLK,
    input  logic               RSTN,
    input  logic               push,
    input  logic               restart,
    input  logic [PIX_W-1:0]   pix,
    output logic               done_c,
    output logic [4*PIX_W-1:0] word_c
);

    logic [1:0]            lane_q;
    logic [1:0]            lane_eff;
    logic [2:0][PIX_W-1:0] hold_q;

    // A restart makes the current pixel lane 0 and abandons earlier lanes.
    always_comb begin
        lane_eff = restart ? 2'd0 : lane_q;
        done_c   = push & (lane_eff == 2'd3);
        word_c   = {hold_q[0], hold_q[1], hold_q[2], pix};
    end

    always_ff @(posedge GCLK or negedge RSTN) begin
        if (!RSTN) begin
            lane_q <= 2'd0;
            hold_q <= '0;
        end else if (push) begin
            lane_q <= lane_eff + 2'd1;
            case (lane_eff)
                2'd0:    hold_q[0] <= pix;
                2'd1:    hold_q[1] <= pix;
                2'd2:    hold_q[2] <= pix;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_block_writer.sv
// Raster pixel stream to 4x4-block frame memory writer (one 32-bit word per block row).
// Optional: FRAME_DOUBLE_BUF_EN adds a wr_bank toggle at every frame end.
module frame_block_writer
    import fb_pkg::*;
(
    input  logic              GCLK,
    input  logic              RSTN,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int unsigned X_W = $clog2(H_PIX);
    localparam int unsigned Y_W = $clog2(V_PIX);

    logic [X_W-1:0]    x_q, x_d, cur_x;
    logic [Y_W-1:0]    y_q, y_d, cur_y;
    logic [ADDR_W-1:0] blk_row, blk_col;
    logic              accept, sof_err_c, last_c, word_done;
    logic [WORD_W-1:0] word;
    logic              wr_en_q, frame_done_q, sync_err_q;
    wr_req_t           req_q, req_d;

    // The output register is the only buffer; it frees up as it drains.
    assign pix_ready = RSTN & (~wr_en_q | wr_ready);
    assign accept    = pix_valid & pix_ready;
    assign sof_err_c = accept & pix_sof & ((x_q != '0) | (y_q != '0));
    assign last_c    = wr_en_q & wr_ready & (req_q.addr == ADDR_W'(NUM_BLKS - 1))
                       & (req_q.sel == SEL_W'(BLK_DIM - 1));

    pixel_packer #(.PIX_W(PIX_W)) u_packer (
        .GCLK    (GCLK),
        .RSTN    (RSTN),
        .push    (accept),
        .restart (sof_err_c),
        .pix     (pix_data),
        .done_c  (word_done),
        .word_c  (word)
    );

    // Coordinates of the pixel being accepted, and the raster position after it.
    always_comb begin
        cur_x = sof_err_c ? '0 : x_q;
        cur_y = sof_err_c ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (accept) begin
            if (cur_x == X_W'(H_PIX - 1)) begin
                x_d = '0;
                y_d = (cur_y == Y_W'(V_PIX - 1)) ? '0 : cur_y + Y_W'(1);
            end else begin
                x_d = cur_x + X_W'(1);
                y_d = cur_y;
            end
        end
    end

    // Block index = (y/4)*80 + x/4, with the *80 as (<<6)+(<<4).
    always_comb begin
        blk_row    = ADDR_W'(cur_y[Y_W-1:2]);
        blk_col    = ADDR_W'(cur_x[X_W-1:2]);
        req_d.addr = (blk_row << 6) + (blk_row << 4) + blk_col;
        req_d.sel  = cur_y[1:0];
        req_d.data = word;
    end

    always_ff @(posedge GCLK or negedge RSTN) begin
        if (!RSTN) begin
            x_q          <= '0;
            y_q          <= '0;
            wr_en_q      <= 1'b0;
            req_q        <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= last_c;
            sync_err_q   <= sof_err_c;
            if (word_done) begin
                wr_en_q <= 1'b1;
                req_q   <= req_d;
            end else if (wr_en_q & wr_ready) begin
                wr_en_q <= 1'b0;
            end
        end
    end

`ifdef FRAME_DOUBLE_BUF_EN
    logic bank_q;

    always_ff @(posedge GCLK or negedge RSTN) begin
        if (!RSTN) begin
            bank_q <= 1'b0;
        end else if (last_c) begin
            bank_q <= ~bank_q;
        end
    end

    assign wr_bank = bank_q;
`else
    assign wr_bank = 1'b0;
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = req_q.addr;
    assign wr_sel     = req_q.sel;
    assign wr_data    = req_q.data;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_frame_block_writer.sv
// Scoreboard bench for frame_block_writer: a raster model queues expected words, the monitor pops them.
module tb_frame_block_writer;
    import fb_pkg::*;

    logic        GCLK = 1'b0;
    logic        RSTN;
    logic        pix_valid, pix_ready, pix_sof;
    logic [7:0]  pix_data;
    logic        wr_en, wr_ready, wr_bank, frame_done, sync_err;
    logic [12:0] wr_addr;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;

    frame_block_writer dut (
        .GCLK(GCLK), .RSTN(RSTN),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_bank(wr_bank), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        logic [12:0] addr;
        logic [1:0]  sel;
        logic [31:0] data;
        int          x0;
        int          y0;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0, errors = 0;
    int          mx = 0, my = 0, mx0 = 0, my0 = 0;
    logic [31:0] mword = '0;
    logic        serr_exp = 0, done_exp = 0, lat_exp = 0, bank_exp = 0, stall_prev = 0;
    logic [12:0] h_addr;
    logic [1:0]  h_sel;
    logic [31:0] h_data;
    int          wr_count = 0, done_count = 0, serr_count = 0;
    logic [12:0] last_addr = '0;
    logic [1:0]  last_sel = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge GCLK) begin
        if (!RSTN) begin
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_sel", wr_sel, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_sync_err", sync_err, 0);
            chk("rst_wr_bank", wr_bank, 0);
            chk("rst_pix_ready", pix_ready, 0);
            sbq.delete();
            mx = 0; my = 0;
            serr_exp = 0; done_exp = 0; lat_exp = 0; bank_exp = 0; stall_prev = 0;
        end else begin
            chk("pix_ready", pix_ready, !wr_en || wr_ready);
            chk("sync_err", sync_err, serr_exp);
            chk("frame_done", frame_done, done_exp);
            chk("wr_bank", wr_bank, bank_exp);
            if (lat_exp) chk("latency", wr_en, 1);
            if (stall_prev) begin
                chk("hold_en", wr_en, 1);
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_sel", wr_sel, h_sel);
                chk("hold_data", wr_data, h_data);
            end
            if (sync_err) serr_count++;
            if (frame_done) done_count++;
            serr_exp = 0; done_exp = 0; lat_exp = 0;

            if (wr_en && wr_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_sel", wr_sel, e.sel);
                    chk("wr_data", wr_data, e.data);
                    if (e.x0 == 4 && e.y0 == 5) begin
                        chk("pix45_addr", wr_addr, 13'd81);
                        chk("pix45_sel", wr_sel, 2'd1);
                    end
                    if (e.addr == 13'd4799 && e.sel == 2'd3) begin
                        done_exp = 1;
`ifdef FRAME_DOUBLE_BUF_EN
                        bank_exp = ~bank_exp;
`endif
                    end
                end
                wr_count++;
                last_addr = wr_addr; last_sel = wr_sel; last_data = wr_data;
            end
            stall_prev = wr_en && !wr_ready;
            h_addr = wr_addr; h_sel = wr_sel; h_data = wr_data;

            if (pix_valid && pix_ready) begin
                if (pix_sof && (mx != 0 || my != 0)) begin
                    serr_exp = 1; mx = 0; my = 0;
                end
                if (mx % 4 == 0) begin
                    mword = {24'h0, pix_data}; mx0 = mx; my0 = my;
                end else begin
                    mword = {mword[23:0], pix_data};
                end
                if (mx % 4 == 3) begin
                    sbq.push_back('{addr: 13'((my / 4) * 80 + mx / 4), sel: 2'(my % 4),
                                    data: mword, x0: mx0, y0: my0});
                    lat_exp = 1;
                end
                mx++;
                if (mx == H_PIX) begin
                    mx = 0; my++;
                    if (my == V_PIX) my = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s);
        int   budget = 0;
        logic took = 0;
        pix_valid = 1; pix_data = d; pix_sof = s;
        while (!took) begin
            @(negedge GCLK);
            took = pix_ready;
            @(posedge GCLK); #1;
            budget++;
            if (!took && budget > 200) begin
                chk("send_timeout", 0, 1);
                took = 1;
            end
        end
    endtask

    task automatic idle();
        pix_valid = 0; pix_sof = 0;
    endtask

    task automatic do_reset();
        idle();
        RSTN = 0;
        repeat (3) @(posedge GCLK);
        #1 RSTN = 1;
    endtask

    task automatic drain();
        int budget = 0;
        while (sbq.size() != 0 && budget < 2000) begin
            @(posedge GCLK); budget++;
        end
        repeat (3) @(posedge GCLK);
        #1;
        if (sbq.size() != 0) chk("drain", sbq.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_wr, base_done, base_serr;
        RSTN = 0; wr_ready = 1; pix_valid = 0; pix_sof = 0; pix_data = '0;
        repeat (3) @(posedge GCLK);
        #1 RSTN = 1;

        // First word after reset
        base_wr = wr_count;
        send(8'h11, 1); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        idle(); drain();
        chk("t1_count", wr_count - base_wr, 1);
        chk("t1_addr", last_addr, 0);
        chk("t1_sel", last_sel, 0);
        chk("t1_data", last_data, 32'h11223344);

        // Full frame with data = x[7:0]
        do_reset();
        base_wr = wr_count; base_done = done_count; base_serr = serr_count;
        for (int y = 0; y < V_PIX; y++)
            for (int x = 0; x < H_PIX; x++)
                send(8'(x), (x == 0 && y == 0));
        idle(); drain();
        chk("frame_writes", wr_count - base_wr, 19200);
        chk("frame_done_count", done_count - base_done, 1);
        chk("frame_serr_count", serr_count - base_serr, 0);
        chk("frame_last_addr", last_addr, 13'd4799);
        chk("frame_last_sel", last_sel, 2'd3);

        // First line of the following frame exercises the bank state
        for (int x = 0; x < H_PIX; x++) send(8'(x), (x == 0));
        idle(); drain();
`ifdef FRAME_DOUBLE_BUF_EN
        chk("frame2_bank", wr_bank, 1);
`else
        chk("frame2_bank", wr_bank, 0);
`endif

        // Backpressure: wr_ready low while a word is pending
        do_reset();
        base_wr = wr_count;
        wr_ready = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(8'(8'hA0 + i), (i == 0));
                idle();
            end
            begin
                repeat (16) @(posedge GCLK);
                #1 wr_ready = 1;
            end
        join
        drain();
        chk("stall_count", wr_count - base_wr, 3);
        chk("stall_last_addr", last_addr, 2);
        chk("stall_last_data", last_data, 32'hA8A9AAAB);

        // Mid-frame sof at pixel (6,0)
        do_reset();
        base_wr = wr_count; base_serr = serr_count;
        for (int i = 0; i < 6; i++) send(8'(i + 1), (i == 0));
        send(8'h77, 1); send(8'h78, 0); send(8'h79, 0); send(8'h7A, 0);
        idle(); drain();
        chk("sof_writes", wr_count - base_wr, 2);
        chk("sof_serr_count", serr_count - base_serr, 1);
        chk("sof_addr", last_addr, 0);
        chk("sof_sel", last_sel, 0);
        chk("sof_data", last_data, 32'h7778797A);

        // Reset with a pending write, then with a lane-2 partial word
        for (int k = 0; k < 2; k++) begin
            do_reset();
            wr_ready = (k == 1);
            for (int i = 0; i < (k == 0 ? 4 : 6); i++) send(8'(i + 1), (i == 0));
            idle();
            if (k == 0) chk("pend_wr_en", wr_en, 1);
            RSTN = 0;
            #1;
            chk("rstmid_wr_en", wr_en, 0);
            chk("rstmid_pix_ready", pix_ready, 0);
            repeat (2) @(posedge GCLK);
            #1 RSTN = 1; wr_ready = 1;
            base_wr = wr_count;
            send(8'hC0, 1); send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0);
            idle(); drain();
            chk("rstmid_count", wr_count - base_wr, 1);
            chk("rstmid_addr", last_addr, 0);
            chk("rstmid_data", last_data, 32'hC0C1C2C3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
